mpc_mul_arb_21s_8ns: RTL

MPC_MUL_ARB_21S_8NS -- requirements
Module: mpc_mul_arb_21s_8ns

---
 rtl/mpc_mul_arb_pkg.sv | 12 +
 rtl/mpc_mul_pipe.sv | 53 +++++
 rtl/mpc_mul_arb_21s_8ns.sv | 105 ++++++++++
 3 files changed

// File: rtl/mpc_mul_arb_pkg.sv
// Shared defaults for the arbitrated signed-by-unsigned multiplier.
// Every width in the top and the multiplier pipe derives from these.
package mpc_mul_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int A_W_DEF   = 21;
   localparam int B_W_DEF   = 8;
   localparam int P_W_DEF   = 30;
   localparam int LAT_DEF   = 4;
   localparam int ID_W_DEF  = $clog2(N_REQ_DEF);

endpackage

// File: rtl/mpc_mul_pipe.sv
// LAT-stage signed(A) x unsigned(B) multiplier with a global clock enable.
// Operands are registered first, then the product is pipelined (DSP A/B -> M -> P).
module mpc_mul_pipe
   import mpc_mul_arb_pkg::*;
#(
   parameter int A_W = A_W_DEF,
   parameter int B_W = B_W_DEF,
   parameter int P_W = P_W_DEF,
   parameter int LAT = LAT_DEF
) (
   input  logic           clk,
   input  logic           ce,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [P_W-1:0] p
);

   logic signed [A_W-1:0] a_q;
   logic        [B_W-1:0] b_q;
   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;
   logic signed [P_W-1:0] prod;

   always_ff @(posedge clk) begin
      if (ce) begin
         a_q <= a;
         b_q <= b;
      end
   end

   // a sign-extends, b zero-extends; P_W >= A_W+B_W keeps the low P_W bits exact
   assign a_ext = P_W'(a_q);
   assign b_ext = P_W'({1'b0, b_q});
   assign prod  = a_ext * b_ext;

   generate
      if (LAT == 1) begin : g_lat1
         assign p = prod;
      end else begin : g_latn
         logic signed [P_W-1:0] p_q [2:LAT];

         always_ff @(posedge clk) begin
            if (ce) begin
               p_q[2] <= prod;
               for (int k = 3; k <= LAT; k++) p_q[k] <= p_q[k-1];
            end
         end

         assign p = p_q[LAT];
      end
   endgenerate

endmodule

// File: rtl/mpc_mul_arb_21s_8ns.sv
// Round-robin arbiter feeding one shared pipelined multiplier; valid/id ride
// a shift register beside the datapath and the whole pipe freezes on back-pressure.
module mpc_mul_arb_21s_8ns
   import mpc_mul_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int P_W   = P_W_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*A_W-1:0]     req_a,
   input  logic [N_REQ*B_W-1:0]     req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [P_W-1:0]           rsp_p,
   output logic                     busy
);

   localparam int ID_W = $clog2(N_REQ);

   logic            adv;
   logic            xfer;
   logic            grant_vld;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] rr_ptr;
   logic [A_W-1:0]  sel_a;
   logic [B_W-1:0]  sel_b;
   logic [LAT:1]    vld_pipe;
   logic [ID_W-1:0] id_pipe [1:LAT];

   assign adv = !(rsp_valid && !rsp_ready);

   // Descending scan so the smallest offset from rr_ptr is the last (winning) write
   always_comb begin
      logic [ID_W-1:0] idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = rr_ptr + ID_W'(k);
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (adv && !reset && grant_vld) req_ready[grant_id] = 1'b1;
   end

   assign xfer  = |(req_valid & req_ready);
   assign sel_a = req_a[grant_id*A_W +: A_W];
   assign sel_b = req_b[grant_id*B_W +: B_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= grant_id + ID_W'(1);
      end
   end

   // Bubbles shift too, so vld_pipe stays aligned with the multiplier stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
      end else if (adv) begin
         for (int k = LAT; k >= 2; k--) vld_pipe[k] <= vld_pipe[k-1];
         vld_pipe[1] <= xfer;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         for (int k = LAT; k >= 2; k--) id_pipe[k] <= id_pipe[k-1];
         id_pipe[1] <= grant_id;
      end
   end

   mpc_mul_pipe #(
      .A_W (A_W),
      .B_W (B_W),
      .P_W (P_W),
      .LAT (LAT)
   ) u_mul (
      .clk (clk),
      .ce  (adv),
      .a   (sel_a),
      .b   (sel_b),
      .p   (rsp_p)
   );

   assign rsp_valid = vld_pipe[LAT];
   assign rsp_id    = id_pipe[LAT];
   assign busy      = |vld_pipe;

endmodule
